// File: rtl/ahb_master_arb.sv
// rtl/ahb_master_arb.sv - two-requester AHB master with round-robin arbitration
// Define ARB_FIXED_PRIORITY_EN to make requester 0 win every contested arbitration.
module ahb_master_arb #(
  parameter int HSIZE  = 2,
  parameter int MAXLEN = 4
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [1:0]  req,
  input  logic [1:0]  cmd_wr,
  input  logic [63:0] cmd_addr,
  input  logic [5:0]  cmd_len,
  input  logic [63:0] cmd_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  wd_pop,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_id,
  output logic [1:0]  done,
  output logic [31:0] Haddr,
  output logic [31:0] Hwdata,
  output logic        Hwrite,
  output logic        Hreadyin,
  output logic [1:0]  Htrans,
  output logic [2:0]  Hsize,
  output logic [2:0]  Hburst,
  input  logic        Hreadyout,
  input  logic [31:0] Hrdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_LAST} state_t;

  localparam logic [31:0] ADDR_INC   = 32'd1 << HSIZE;
  localparam logic [2:0]  MAX_LEN_M1 = 3'(MAXLEN - 1);

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic        r_gidx;
  logic        r_rr_ptr;
  logic [2:0]  r_left;
  logic [31:0] r_haddr;
  logic [31:0] r_hwdata;
  logic        r_hwrite;
  logic        r_hreadyin;
  logic [1:0]  r_htrans;
  logic [2:0]  r_hburst;
  logic        r_rd_valid;
  logic [31:0] r_rd_data;
  logic        r_rd_id;
  logic [1:0]  r_done;

  logic        w_pick;
  logic [2:0]  w_len_raw;
  logic [2:0]  w_len;
  logic        w_addr_phase;

  always_comb begin
    w_pick = req[1] & ~req[0];
    if (&req) begin
`ifdef ARB_FIXED_PRIORITY_EN
      w_pick = 1'b0;
`else
      w_pick = r_rr_ptr;
`endif
    end
  end

  assign w_len_raw    = w_pick ? cmd_len[5:3] : cmd_len[2:0];
  assign w_len        = (w_len_raw > MAX_LEN_M1) ? MAX_LEN_M1 : w_len_raw;
  assign w_addr_phase = (r_state == S_ADDR) || (r_state == S_BURST);

  // Combinational so the requester can present its next beat on the following cycle.
  assign wd_pop = (w_addr_phase && r_hwrite && Hreadyout) ? r_gnt : 2'b00;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state    <= S_IDLE;
      r_gnt      <= 2'b00;
      r_gidx     <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_left     <= 3'd0;
      r_haddr    <= 32'd0;
      r_hwdata   <= 32'd0;
      r_hwrite   <= 1'b0;
      r_hreadyin <= 1'b0;
      r_htrans   <= 2'b00;
      r_hburst   <= 3'b000;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 32'd0;
      r_rd_id    <= 1'b0;
      r_done     <= 2'b00;
    end else begin
      r_hreadyin <= 1'b1;
      r_rd_valid <= 1'b0;
      r_done     <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gidx   <= w_pick;
            r_gnt    <= w_pick ? 2'b10 : 2'b01;
            r_haddr  <= w_pick ? cmd_addr[63:32] : cmd_addr[31:0];
            r_hwrite <= cmd_wr[w_pick];
            r_left   <= w_len;
            r_hburst <= (w_len == 3'd0) ? 3'b000 : 3'b001;
            r_htrans <= 2'b10;
            r_state  <= S_ADDR;
          end
        end
        S_ADDR, S_BURST: begin
          if (Hreadyout) begin
            // In BURST the previous beat's data phase completes alongside this address phase.
            if (r_state == S_BURST && !r_hwrite) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= Hrdata;
              r_rd_id    <= r_gidx;
            end
            if (r_hwrite) begin
              r_hwdata <= r_gidx ? cmd_wdata[63:32] : cmd_wdata[31:0];
            end
            r_haddr <= r_haddr + ADDR_INC;
            if (r_left == 3'd0) begin
              r_htrans <= 2'b00;
              r_state  <= S_LAST;
            end else begin
              r_left   <= r_left - 3'd1;
              r_htrans <= 2'b11;
              r_state  <= S_BURST;
            end
          end
        end
        S_LAST: begin
          if (Hreadyout) begin
            if (!r_hwrite) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= Hrdata;
              r_rd_id    <= r_gidx;
            end
            r_done   <= r_gnt;
            r_gnt    <= 2'b00;
            r_rr_ptr <= ~r_gidx;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_id    = r_rd_id;
  assign done     = r_done;
  assign Haddr    = r_haddr;
  assign Hwdata   = r_hwdata;
  assign Hwrite   = r_hwrite;
  assign Hreadyin = r_hreadyin;
  assign Htrans   = r_htrans;
  assign Hsize    = 3'(HSIZE);
  assign Hburst   = r_hburst;

endmodule

// File: tb/tb_ahb_master_arb.sv
// tb/tb_ahb_master_arb.sv - directed self-checking bench for ahb_master_arb
// Covers single write, read burst, wait states, arbitration, async reset and address wrap.
module tb_ahb_master_arb;

  logic        Hclk;
  logic        Hresetn;
  logic [1:0]  req;
  logic [1:0]  cmd_wr;
  logic [63:0] cmd_addr;
  logic [5:0]  cmd_len;
  logic [63:0] cmd_wdata;
  logic [1:0]  gnt;
  logic [1:0]  wd_pop;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_id;
  logic [1:0]  done;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic [2:0]  Hburst;
  logic        Hreadyout;
  logic [31:0] Hrdata;

  int n_cmp  = 0;
  int n_fail = 0;

  ahb_master_arb dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .req       (req),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_wdata (cmd_wdata),
    .gnt       (gnt),
    .wd_pop    (wd_pop),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_id     (rd_id),
    .done      (done),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Hsize     (Hsize),
    .Hburst    (Hburst),
    .Hreadyout (Hreadyout),
    .Hrdata    (Hrdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  initial begin
    Hresetn   = 1'b0;
    req       = 2'b00;
    cmd_wr    = 2'b00;
    cmd_addr  = 64'd0;
    cmd_len   = 6'd0;
    cmd_wdata = 64'd0;
    Hreadyout = 1'b1;
    Hrdata    = 32'd0;

    // Reset state
    step();
    chk("rst_htrans", 32'(Htrans), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_hreadyin", 32'(Hreadyin), 32'h0);
    chk("rst_haddr", Haddr, 32'h0);
    chk("rst_hwdata", Hwdata, 32'h0);
    chk("rst_hsize", 32'(Hsize), 32'h2);
    chk("rst_hburst", 32'(Hburst), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    Hresetn = 1'b1;
    step();
    chk("idle_hreadyin", 32'(Hreadyin), 32'h1);
    chk("idle_htrans", 32'(Htrans), 32'h0);

    // Single write from requester 0
    req = 2'b01; cmd_wr = 2'b01;
    cmd_addr[31:0] = 32'h8000_0000; cmd_len[2:0] = 3'd0; cmd_wdata[31:0] = 32'h80;
    step();
    chk("sw_gnt", 32'(gnt), 32'h1);
    chk("sw_htrans", 32'(Htrans), 32'h2);
    chk("sw_haddr", Haddr, 32'h8000_0000);
    chk("sw_hwrite", 32'(Hwrite), 32'h1);
    chk("sw_hburst", 32'(Hburst), 32'h0);
    chk("sw_wd_pop", 32'(wd_pop), 32'h1);
    req = 2'b00;
    step();
    chk("sw_last_htrans", 32'(Htrans), 32'h0);
    chk("sw_hwdata", Hwdata, 32'h80);
    chk("sw_last_wd_pop", 32'(wd_pop), 32'h0);
    chk("sw_last_done", 32'(done), 32'h0);
    step();
    chk("sw_done", 32'(done), 32'h1);
    chk("sw_gnt_drop", 32'(gnt), 32'h0);
    step();
    chk("sw_done_pulse", 32'(done), 32'h0);

    // Read burst from requester 1
    req = 2'b10; cmd_wr = 2'b00;
    cmd_addr[63:32] = 32'h8000_0048; cmd_len[5:3] = 3'd3;
    step();
    chk("rb_gnt", 32'(gnt), 32'h2);
    chk("rb_haddr0", Haddr, 32'h8000_0048);
    chk("rb_htrans0", 32'(Htrans), 32'h2);
    chk("rb_hburst", 32'(Hburst), 32'h1);
    chk("rb_hwrite", 32'(Hwrite), 32'h0);
    chk("rb_wd_pop", 32'(wd_pop), 32'h0);
    req = 2'b00;
    step();
    chk("rb_haddr1", Haddr, 32'h8000_004C);
    chk("rb_htrans1", 32'(Htrans), 32'h3);
    chk("rb_no_rv", 32'(rd_valid), 32'h0);
    Hrdata = 32'hD0;
    step();
    chk("rb_rv0", 32'(rd_valid), 32'h1);
    chk("rb_rd0", rd_data, 32'hD0);
    chk("rb_id0", 32'(rd_id), 32'h1);
    chk("rb_haddr2", Haddr, 32'h8000_0050);
    chk("rb_htrans2", 32'(Htrans), 32'h3);
    Hrdata = 32'hD1;
    step();
    chk("rb_rv1", 32'(rd_valid), 32'h1);
    chk("rb_rd1", rd_data, 32'hD1);
    chk("rb_haddr3", Haddr, 32'h8000_0054);
    chk("rb_htrans3", 32'(Htrans), 32'h3);
    Hrdata = 32'hD2;
    step();
    chk("rb_rv2", 32'(rd_valid), 32'h1);
    chk("rb_rd2", rd_data, 32'hD2);
    chk("rb_last_htrans", 32'(Htrans), 32'h0);
    chk("rb_last_done", 32'(done), 32'h0);
    Hrdata = 32'hD3;
    step();
    chk("rb_rv3", 32'(rd_valid), 32'h1);
    chk("rb_rd3", rd_data, 32'hD3);
    chk("rb_id3", 32'(rd_id), 32'h1);
    chk("rb_done", 32'(done), 32'h2);
    chk("rb_gnt_drop", 32'(gnt), 32'h0);
    step();
    chk("rb_rv_end", 32'(rd_valid), 32'h0);

    // Write burst with two wait states during beat 2
    req = 2'b01; cmd_wr = 2'b01;
    cmd_addr[31:0] = 32'h0000_1000; cmd_len[2:0] = 3'd3; cmd_wdata[31:0] = 32'hA0;
    step();
    chk("wb_haddr0", Haddr, 32'h0000_1000);
    chk("wb_wd_pop0", 32'(wd_pop), 32'h1);
    req = 2'b00;
    step();
    cmd_wdata[31:0] = 32'hA1;
    chk("wb_haddr1", Haddr, 32'h0000_1004);
    chk("wb_hwdata0", Hwdata, 32'hA0);
    chk("wb_wd_pop1", 32'(wd_pop), 32'h1);
    step();
    cmd_wdata[31:0] = 32'hA2;
    Hreadyout = 1'b0;
    #1;
    chk("wb_haddr2", Haddr, 32'h0000_1008);
    chk("wb_hwdata1", Hwdata, 32'hA1);
    chk("wb_wait_pop", 32'(wd_pop), 32'h0);
    step();
    chk("wb_hold1_haddr", Haddr, 32'h0000_1008);
    chk("wb_hold1_htrans", 32'(Htrans), 32'h3);
    chk("wb_hold1_hwdata", Hwdata, 32'hA1);
    chk("wb_hold1_pop", 32'(wd_pop), 32'h0);
    step();
    chk("wb_hold2_haddr", Haddr, 32'h0000_1008);
    chk("wb_hold2_hwdata", Hwdata, 32'hA1);
    chk("wb_hold2_hburst", 32'(Hburst), 32'h1);
    Hreadyout = 1'b1;
    #1;
    chk("wb_resume_pop", 32'(wd_pop), 32'h1);
    step();
    cmd_wdata[31:0] = 32'hA3;
    chk("wb_haddr3", Haddr, 32'h0000_100C);
    chk("wb_hwdata2", Hwdata, 32'hA2);
    chk("wb_htrans3", 32'(Htrans), 32'h3);
    step();
    chk("wb_last_htrans", 32'(Htrans), 32'h0);
    chk("wb_hwdata3", Hwdata, 32'hA3);
    step();
    chk("wb_done", 32'(done), 32'h1);
    step();

    // Asynchronous reset in the middle of a read burst
    req = 2'b01; cmd_wr = 2'b00;
    cmd_addr[31:0] = 32'h0000_2000; cmd_len[2:0] = 3'd3;
    step();
    req = 2'b00;
    step();
    chk("ar_pre_htrans", 32'(Htrans), 32'h3);
    Hresetn = 1'b0;
    #1;
    chk("ar_htrans", 32'(Htrans), 32'h0);
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_haddr", Haddr, 32'h0);
    chk("ar_hreadyin", 32'(Hreadyin), 32'h0);
    step();
    Hresetn = 1'b1;
    step();
    chk("ar_post_htrans", 32'(Htrans), 32'h0);
    chk("ar_post_done", 32'(done), 32'h0);
    step();
    chk("ar_post_done2", 32'(done), 32'h0);

    // Both requesters continuously requesting single-beat reads
    req = 2'b11; cmd_wr = 2'b00; cmd_len = 6'd0;
    step();
    chk("arb_g0", 32'(gnt), 32'h1);
    step();
    step();
    chk("arb_done0", 32'(done), 32'h1);
    step();
`ifdef ARB_FIXED_PRIORITY_EN
    chk("arb_g1", 32'(gnt), 32'h1);
`else
    chk("arb_g1", 32'(gnt), 32'h2);
`endif
    step();
    step();
    step();
    chk("arb_g2", 32'(gnt), 32'h1);
    req = 2'b00;
    step();
    step();
    chk("arb_done2", 32'(done), 32'h1);
    step();

    // Address wrap past 0xFFFF_FFFC
    req = 2'b01; cmd_wr = 2'b01;
    cmd_addr[31:0] = 32'hFFFF_FFFC; cmd_len[2:0] = 3'd1; cmd_wdata[31:0] = 32'h55;
    step();
    chk("wr_haddr0", Haddr, 32'hFFFF_FFFC);
    chk("wr_hburst", 32'(Hburst), 32'h1);
    req = 2'b00;
    step();
    chk("wr_haddr1", Haddr, 32'h0000_0000);
    chk("wr_htrans1", 32'(Htrans), 32'h3);
    step();
    chk("wr_last_htrans", 32'(Htrans), 32'h0);
    step();
    chk("wr_done", 32'(done), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
